muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide, with signed magnitude conversion and fixup.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;

  logic             is_div;
  logic             is_rem;
  logic             x_sgn;
  logic             y_sgn;
  logic             x_neg;
  logic             y_neg;
  logic             dz;
  logic             ovf;
  logic             neg_in;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;

  assign is_div = op[2];
  assign is_rem = op[2] & op[1];
  assign x_sgn  = (op == 3'd1) || (op == 3'd2) ||
                  (op == 3'd4) || (op == 3'd6);
  assign y_sgn  = (op == 3'd1) || (op == 3'd4) ||
                  (op == 3'd6);
  assign x_neg  = x_sgn & X[WIDTH-1];
  assign y_neg  = y_sgn & Y[WIDTH-1];
  assign x_abs  = x_neg ? -X : X;
  assign y_abs  = y_neg ? -Y : Y;
  assign dz     = is_div && (Y == '0);
  assign ovf    = is_div && !op[0] &&
                  (X == MIN) && (Y == ONES);
  // remainder follows the dividend sign only
  assign neg_in = is_rem ? x_neg : (x_neg ^ y_neg);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             last;
  logic [WIDTH-1:0] nh;
  logic [WIDTH-1:0] nl;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] fix;
  logic [2*WIDTH-1:0] prod;

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sum  = {1'b0, acc_hi} +
           (acc_lo[0] ? {1'b0, mag} : '0);
    sh   = {acc_hi, acc_lo[WIDTH-1]};
    diff = sh - {1'b0, mag};
    ge   = ~diff[WIDTH];
    if (op_q[2]) begin
      nh = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      nl = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nh = sum[WIDTH:1];
      nl = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod = {nh, nl};
    if (neg_q) prod = -prod;
    q_s = neg_q ? -nl : nl;
    r_s = neg_q ? -nh : nh;
    fix = '0;
    unique case (1'b1)
      op_q == 3'd0:
        fix = prod[WIDTH-1:0];
      !op_q[2] && (op_q[1:0] != 2'd0):
        fix = prod[2*WIDTH-1:WIDTH];
      op_q[2] && !op_q[1]:
        fix = q_s;
      op_q[2] && op_q[1]:
        fix = r_s;
      default:
        fix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (start) state_nx = (dz || ovf) ? DONE : CALC;
      CALC:
        if (last) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      mag      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      result   <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          neg_q  <= neg_in;
          cnt    <= '0;
          acc_hi <= '0;
          mag    <= is_div ? y_abs : x_abs;
          acc_lo <= is_div ? x_abs : y_abs;
          if (dz) begin
            result   <= is_rem ? X : ONES;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else if (ovf) begin
            result   <= is_rem ? '0 : X;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end
        end
        CALC: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= nh;
          acc_lo <= nl;
          if (last) begin
            result   <= fix;
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a native
// arithmetic model through an expected-result queue.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_zero;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .X        (X),
    .Y        (Y),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(
    input logic [2:0] o,
    input logic [W-1:0] x,
    input logic [W-1:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] uy;
    logic [63:0]        p;
    logic signed [31:0] a;
    logic signed [31:0] b;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'b0, y};
    a  = x;
    b  = y;
    case (o)
      3'd0: begin
        p = {32'b0, x} * {32'b0, y};
        return p[31:0];
      end
      3'd1: begin
        p = sx * sy;
        return p[63:32];
      end
      3'd2: begin
        p = sx * uy;
        return p[63:32];
      end
      3'd3: begin
        p = {32'b0, x} * {32'b0, y};
        return p[63:32];
      end
      3'd4: return a / b;
      3'd5: return x / y;
      3'd6: return a % b;
      default: return x % y;
    endcase
  endfunction

  task automatic run(input logic [2:0] o,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic [W-1:0] er,
                     input logic ez,
                     input logic eo,
                     input string tag,
                     input bit poke);
    exp_t e;
    int   n;
    int   bc;
    bit   skip;
    skip = ez | eo;
    sb.push_back('{er, ez, eo, tag});
    start = 1'b1;
    op    = o;
    X     = x;
    Y     = y;
    tick();
    start = 1'b0;
    X     = $urandom;
    Y     = $urandom;
    op    = 3'($urandom);
    n  = 0;
    bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (poke && n == 5) begin
        start = 1'b1;
        op    = 3'd5;
        X     = 5;
        Y     = 0;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, " edges"}, 64'(n + 1),
          skip ? 64'd1 : 64'(W + 1));
    check({tag, " busy"}, 64'(bc),
          skip ? 64'd0 : 64'(W));
    e = sb.pop_front();
    check({tag, " result"}, 64'(result), 64'(e.res));
    check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
    check({tag, " overflow"}, 64'(overflow), 64'(e.ovf));
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " pulse"}, 64'({busy, done}), 64'd0);
    check({tag, " hold"}, 64'(result), 64'(e.res));
  endtask

  initial begin
    int nd;
    int nb;
    logic [2:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    X     = '0;
    Y     = '0;
    tick();
    tick();
    check("reset state",
          64'({busy, done, div_zero, overflow, result}),
          64'd0);
    reset = 1'b0;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB,
        1'b0, 1'b0, "mul", 1'b0);
    run(3'd1, MIN, MIN, 32'h4000_0000,
        1'b0, 1'b0, "mulh", 1'b0);
    run(3'd3, ONES, ONES, 32'hFFFF_FFFE,
        1'b0, 1'b0, "mulhu", 1'b0);
    run(3'd2, ONES, ONES, 32'hFFFF_FFFF,
        1'b0, 1'b0, "mulhsu", 1'b0);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD,
        1'b0, 1'b0, "div", 1'b0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF,
        1'b0, 1'b0, "rem", 1'b0);
    run(3'd5, 32'd100, 32'd7, 32'd14,
        1'b0, 1'b0, "divu", 1'b0);
    run(3'd7, 32'd100, 32'd7, 32'd2,
        1'b0, 1'b0, "remu", 1'b0);
    run(3'd5, 32'd5, 32'd0, ONES,
        1'b1, 1'b0, "divu0", 1'b0);
    run(3'd6, 32'd5, 32'd0, 32'd5,
        1'b1, 1'b0, "rem0", 1'b0);
    run(3'd4, MIN, ONES, MIN,
        1'b0, 1'b1, "div_ovf", 1'b0);
    run(3'd6, MIN, ONES, 32'd0,
        1'b0, 1'b1, "rem_ovf", 1'b0);
    run(3'd0, 32'd6, 32'd7, 32'd42,
        1'b0, 1'b0, "mul_flags", 1'b0);
    run(3'd0, 32'h0001_2345, 32'h100, 32'h0123_4500,
        1'b0, 1'b0, "start_busy", 1'b1);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      if (i == 0) rx = MIN;
      if (ry == '0 || ry == ONES) ry = 32'd3;
      run(ro, rx, ry, model(ro, rx, ry),
          1'b0, 1'b0, $sformatf("rand%0d", i), 1'b0);
    end

    run(3'd5, 32'd9, 32'd0, ONES,
        1'b1, 1'b0, "pre_abort", 1'b0);
    start = 1'b1;
    op    = 3'd0;
    X     = 32'd123;
    Y     = 32'd456;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("abort busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("abort clear",
          64'({busy, done, div_zero, overflow, result}),
          64'd0);
    reset = 1'b0;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
      if (busy) nb++;
    end
    check("abort no done", 64'(nd), 64'd0);
    check("abort idle", 64'(nb), 64'd0);

    reset = 1'b1;
    start = 1'b1;
    op    = 3'd0;
    X     = 32'd3;
    Y     = 32'd3;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("reset prio", 64'({busy, done}), 64'd0);
    run(3'd0, 32'd3, 32'd5, 32'd15,
        1'b0, 1'b0, "first_after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
